uart_rx_param: RTL and testbench

//  Parametrised UART receiver: configurable data bits, parity and stop bits.

---
 rtl/uart_rx_param.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted sampling, parity/framing flags, valid/ready output.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry show-ahead receive FIFO (default: one holding register).
module uart_rx_param #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_parity_err,
    output logic                               rx_frame_err,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic                               overrun,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

    localparam int LVW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int H   = CLK_DIV / 2;
    localparam int WW  = DATA_BITS + 2;

    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_STOP      = 3'd5;

    logic                 rx_m;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 s0;
    logic                 s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;

    logic                 in_frame;
    logic                 at_dec;
    logic                 cnt_last;
    logic                 bit_val;
    logic                 exp_par;
    logic                 commit;
    logic [WW-1:0]        word;
    logic                 pop;

    // Synchroniser resets low so WAIT_IDLE only exits on a genuinely high line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign in_frame = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
    assign at_dec   = in_frame && (cnt == C_DEC);
    assign cnt_last = cnt == C_LAST;
    assign bit_val  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign exp_par  = (^shreg) ^ (PARITY == 1);
    assign busy     = in_frame;

    assign commit = (state == S_STOP) && at_dec && (bit_idx == SB_LAST);
    assign word   = {shreg, par_err, frm_err | ~bit_val};
    assign pop    = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (in_frame) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
                if (cnt == C_S0) s0 <= rx_s;
                if (cnt == C_S1) s1 <= rx_s;
            end
            case (state)
                S_WAIT_IDLE: begin
                    if (rx_s) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_dec && bit_val) state <= S_IDLE;
                    else if (cnt_last)     state <= S_DATA;
                end
                S_DATA: begin
                    if (at_dec) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (cnt_last) begin
                        if (bit_idx == DB_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_dec)   par_err <= bit_val ^ exp_par;
                    if (cnt_last) state   <= S_STOP;
                end
                S_STOP: begin
                    if (at_dec) begin
                        if (!bit_val) frm_err <= 1'b1;
                        // A low final stop bit means break/line-low: wait for idle first
                        if (bit_idx == SB_LAST)
                            state <= bit_val ? S_IDLE : S_WAIT_IDLE;
                    end else if (cnt_last) begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: state <= S_WAIT_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LVW-1:0] count;
    logic           full;
    logic           do_push;

    assign full    = count == LVW'(FIFO_DEPTH);
    assign do_push = commit && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= commit && full && !pop;
            if (do_push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
        end
    end

    assign {rx_data, rx_parity_err, rx_frame_err} = mem[rd_ptr];
    assign rx_valid = count != '0;
    assign level    = count;
`else
    logic [WW-1:0] hold;
    logic          hold_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= '0;
            hold_v  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit && (!hold_v || pop)) begin
                hold   <= word;
                hold_v <= 1'b1;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end
    end

    assign {rx_data, rx_parity_err, rx_frame_err} = hold;
    assign rx_valid = hold_v;
    assign level    = LVW'(hold_v);
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: vector table, corner sequences, random frames vs model.
// Build with UART_RX_FIFO_EN to exercise the FIFO variant (FIFO_DEPTH=4).
module tb_uart_rx_param;

    localparam int CLK_DIV   = 16;
    localparam int DATA_BITS = 8;
    localparam int PARITY    = 2;
    localparam int STOP_BITS = 1;
`ifdef UART_RX_FIFO_EN
    localparam int FIFO_DEPTH = 4;
`else
    localparam int FIFO_DEPTH = 16;
`endif
    localparam int LVW = $clog2(FIFO_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 rx = 1'b1;
    logic                 man_ready = 1'b1;
    logic                 rnd_ready = 1'b1;
    logic                 rnd_on = 1'b0;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_valid;
    logic                 overrun;
    logic                 busy;
    logic [LVW-1:0]       level;

    assign rx_ready = rnd_on ? rnd_ready : man_ready;

    uart_rx_param #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .PARITY     (PARITY),
        .STOP_BITS  (STOP_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .overrun       (overrun),
        .busy          (busy),
        .level         (level)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         ovr_cnt = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({rx_data, rx_parity_err, rx_frame_err});
        if (overrun) ovr_cnt++;
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        step(CLK_DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    // Even parity: the correct parity bit equals the XOR of the data bits
    function automatic logic [9:0] ref_word(input logic [7:0] d, input logic p, input logic s);
        return {d, p != (^d), ~s};
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] e_d;
        logic       e_pe;
        logic       e_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         bc;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b0, 8'h07, 1'b1, 1'b1};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

        step(3);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_perr", rx_parity_err, 0);
        chk("reset_ferr", rx_frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        chk("reset_level", level, 0);
        reset_n = 1'b1;
        step(2 * CLK_DIV);

        for (int i = 0; i < 7; i++) begin
            got_q.delete();
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
            rx = 1'b1;
            step(2 * CLK_DIV);
            chk($sformatf("vec%0d_count", i), got_q.size(), 1);
            if (got_q.size() > 0) begin
                chk($sformatf("vec%0d_data", i), got_q[0][9:2], vecs[i].e_d);
                chk($sformatf("vec%0d_perr", i), got_q[0][1], vecs[i].e_pe);
                chk($sformatf("vec%0d_ferr", i), got_q[0][0], vecs[i].e_fe);
            end
        end

        // False start: short low glitch while idle
        got_q.delete();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2);
        chk("glitch_busy_hi", busy, 1);
        step(10);
        chk("glitch_busy_lo", busy, 0);
        step(2 * CLK_DIV);
        chk("glitch_no_word", got_q.size(), 0);

        // Break: stop bit low, line held low 40 more cycles
        got_q.delete();
        send_frame(8'h55, 1'b0, 1'b0);
        bc = 0;
        step(4);
        for (int k = 0; k < 36; k++) begin
            if (busy) bc++;
            step(1);
        end
        chk("break_busy_cycles", bc, 0);
        chk("break_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("break_word", got_q[0], ref_word(8'h55, 1'b0, 1'b0));
        rx = 1'b1;
        step(2 * CLK_DIV);
        chk("break_no_extra", got_q.size(), 1);

        // Overrun with the consumer stalled
        got_q.delete();
        man_ready = 1'b0;
        ovr_cnt = 0;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) begin
            rd = 8'(i);
            send_frame(rd, ^rd, 1'b1);
        end
        rx = 1'b1;
        step(2 * CLK_DIV);
        chk("ovr_level", level, 4);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_head", rx_data, 8'h01);
        man_ready = 1'b1;
        step(8);
        chk("ovr_pop_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++) begin
            rd = 8'(i + 1);
            chk($sformatf("ovr_pop%0d", i), got_q[i], ref_word(rd, ^rd, 1'b1));
        end
        chk("ovr_level_empty", level, 0);
`else
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        rx = 1'b1;
        step(2 * CLK_DIV);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_level", level, 1);
        chk("ovr_pulses", ovr_cnt, 1);
        man_ready = 1'b1;
        step(3);
        chk("ovr_pop_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("ovr_pop_word", got_q[0], ref_word(8'h11, 1'b0, 1'b1));
        chk("ovr_valid_after", rx_valid, 0);
`endif

        // Reset mid-frame with a word held in the buffer
        man_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        rx = 1'b1;
        step(8);
        chk("rst_held_valid", rx_valid, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("rst_busy_before", busy, 1);
        reset_n = 1'b0;
        step(2);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        rx = 1'b1;
        reset_n = 1'b1;
        man_ready = 1'b1;
        step(2 * CLK_DIV);
        got_q.delete();
        send_frame(8'h81, 1'b0, 1'b1);
        step(2 * CLK_DIV);
        chk("rst_next_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst_next_word", got_q[0], ref_word(8'h81, 1'b0, 1'b1));

        // Random frames against the reference model, random consumer stalls
        got_q.delete();
        exp_q.delete();
        ovr_cnt = 0;
        rnd_on = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rd = 8'($urandom);
            rp = ($urandom_range(0, 3) == 0) ? ~(^rd) : ^rd;
            rs = ($urandom_range(0, 7) != 0);
            exp_q.push_back(ref_word(rd, rp, rs));
            send_frame(rd, rp, rs);
            rx = 1'b1;
            step(rs ? $urandom_range(0, 20) : $urandom_range(4, 20));
        end
        step(3 * CLK_DIV);
        rnd_on = 1'b0;
        step(4);
        chk("rnd_count", got_q.size(), exp_q.size());
        chk("rnd_overrun", ovr_cnt, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("rnd_word%0d", i), got_q[i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
